des_key_scheduler: RTL and testbench

Sequential DES key-schedule controller. It accepts one 64-bit key, applies PC-1 once, then steps the 56-bit C/D register through the 16 rounds: per-round rotate of each 28-bit half, then PC-2. It emits one 48-bit subkey per round to the round datapath over a valid/ready handshake. It sits between the key input port and the cipher round engine, replacing per-round combinational key mixing with a single registered state.

---
 rtl/des_key_scheduler.sv | 171 +++++++++++++++++
 tb/tb_des_key_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_scheduler.sv
// Sequential DES key schedule: PC-1 once, then one registered rotate + PC-2 per round, handshaked out.
// Optional feature macro: DES_KEYSCHED_DECRYPT_EN (reverse K16..K1 order via right rotations).
module des_key_scheduler #(
    parameter int ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    input  logic        abort,
    output logic [47:0] subkey,
    output logic [4:0]  subkey_round,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] LAST = 5'(ROUNDS);

    // FIPS tables list source bit numbers, bit 1 being the MSB of the source word.
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic {
        IDLE,
        ROUND
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [55:0] cd;
    logic [55:0] cd_next;
    logic [55:0] cd_load;
    logic [55:0] cd_step;
    logic [55:0] pc1_key;
    logic [4:0]  cnt;
    logic        handshake;
    logic        load;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) r[55-i] = k[6'(64 - PC1_TAB[i])];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] c);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) r[47-i] = c[6'(56 - PC2_TAB[i])];
        return r;
    endfunction

    // Rounds 1, 2, 9 and 16 rotate by one; all others by two.
    function automatic logic shift_two(input logic [4:0] r);
        return !(r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16);
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] h, input logic two);
        return two ? {h[25:0], h[27:26]} : {h[26:0], h[27]};
    endfunction

    function automatic logic [55:0] rotl56(input logic [55:0] c, input logic two);
        return {rotl28(c[55:28], two), rotl28(c[27:0], two)};
    endfunction

`ifdef DES_KEYSCHED_DECRYPT_EN
    logic dir;

    function automatic logic [27:0] rotr28(input logic [27:0] h, input logic two);
        return two ? {h[1:0], h[27:2]} : {h[0], h[27:1]};
    endfunction

    function automatic logic [55:0] rotr56(input logic [55:0] c, input logic two);
        return {rotr28(c[55:28], two), rotr28(c[27:0], two)};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dir <= 1'b0;
        else if (load && !abort)
            dir <= decrypt;
    end
`else
    logic unused_decrypt;
    assign unused_decrypt = decrypt;
`endif

    assign handshake = (state == ROUND) && subkey_ready;
    assign load      = (state == IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (start && !abort) state_next = ROUND;
            ROUND: if (abort || (handshake && cnt == LAST)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decrypt loads PC-1 unrotated: the 16 rotations sum to 28, so that is already CD16.
    always_comb begin
        pc1_key = pc1(key_in);
`ifdef DES_KEYSCHED_DECRYPT_EN
        cd_load = decrypt ? pc1_key : rotl56(pc1_key, 1'b0);
        cd_step = dir ? rotr56(cd, shift_two(LAST + 5'd1 - cnt))
                      : rotl56(cd, shift_two(cnt + 5'd1));
`else
        cd_load = rotl56(pc1_key, 1'b0);
        cd_step = rotl56(cd, shift_two(cnt + 5'd1));
`endif
        cd_next = (state == IDLE) ? cd_load : cd_step;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cd     <= '0;
            subkey <= '0;
            cnt    <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!abort) begin
                if (load) begin
                    cd     <= cd_next;
                    subkey <= pc2(cd_next);
                    cnt    <= 5'd1;
                end else if (handshake) begin
                    if (cnt == LAST) begin
                        done <= 1'b1;
                    end else begin
                        cd     <= cd_next;
                        subkey <= pc2(cd_next);
                        cnt    <= cnt + 5'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        busy         = (state == ROUND);
        subkey_valid = (state == ROUND);
`ifdef DES_KEYSCHED_DECRYPT_EN
        subkey_round = dir ? (LAST + 5'd1 - cnt) : cnt;
`else
        subkey_round = cnt;
`endif
    end

endmodule

// File: tb/tb_des_key_scheduler.sv
// Self-checking bench for des_key_scheduler: directed FIPS vectors plus randomized keys and
// backpressure, checked against a C/D-halves reference model. Honours DES_KEYSCHED_DECRYPT_EN.
module tb_des_key_scheduler;

    localparam logic [63:0] VEC_KEY = 64'h133457799BBCDFF1;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] key_in;
    logic        decrypt;
    logic        abort;
    logic [47:0] subkey;
    logic [4:0]  subkey_round;
    logic        subkey_valid;
    logic        subkey_ready;
    logic        busy;
    logic        done;

    int          tests;
    int          failures;
    logic [47:0] ks [1:16];
    logic [63:0] key_a;

    des_key_scheduler #(.ROUNDS(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .key_in       (key_in),
        .decrypt      (decrypt),
        .abort        (abort),
        .subkey       (subkey),
        .subkey_round (subkey_round),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // Bit n in FIPS numbering (1 = MSB) of a word of the given width.
    function automatic logic fips_bit(input logic [63:0] v, input int width, input int n);
        logic [63:0] sh;
        sh = v >> (width - n);
        return sh[0];
    endfunction

    // Reference: split PC-1 into C and D, rotate each arithmetically, and collect K1..K16.
    task automatic build_model(input logic [63:0] key);
        logic [63:0] cd;
        logic [63:0] c;
        logic [63:0] d;
        logic [63:0] full;
        logic [63:0] k;
        int          s;
        cd = 64'h0;
        for (int i = 0; i < 56; i++) cd = (cd << 1) | {63'h0, fips_bit(key, 64, PC1_T[i])};
        c = cd >> 28;
        d = cd & 64'hFFFFFFF;
        for (int r = 1; r <= 16; r++) begin
            s = SHIFTS[r-1];
            c = ((c << s) | (c >> (28 - s))) & 64'hFFFFFFF;
            d = ((d << s) | (d >> (28 - s))) & 64'hFFFFFFF;
            full = (c << 28) | d;
            k = 64'h0;
            for (int i = 0; i < 48; i++) k = (k << 1) | {63'h0, fips_bit(full, 56, PC2_T[i])};
            ks[r] = k[47:0];
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [63:0] key, input logic dec,
                                 input logic rdy, input logic ab);
        start        = st;
        key_in       = key;
        decrypt      = dec;
        subkey_ready = rdy;
        abort        = ab;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready held high; 1: random ready; 2: ready low for 5 cycles at round 9.
    task automatic run_schedule(input logic [63:0] key, input logic dec, input int mode,
                                input string tag);
        int   j;
        int   cycles;
        int   r;
        int   held;
        logic rdy;
        logic eff;
        build_model(key);
`ifdef DES_KEYSCHED_DECRYPT_EN
        eff = dec;
`else
        eff = 1'b0;
`endif
        applyStimulus(1'b1, key, dec, 1'b1, 1'b0);
        j      = 0;
        cycles = 0;
        held   = 0;
        while (j < 16 && cycles < 400) begin
            r = eff ? 16 - j : j + 1;
            checkOutput({tag, "_valid"}, 64'(subkey_valid), 64'h1);
            checkOutput({tag, "_round"}, 64'(subkey_round), 64'(r));
            checkOutput({tag, "_subkey"}, 64'(subkey), 64'(ks[r]));
            checkOutput({tag, "_nodone"}, 64'(done), 64'h0);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 3) != 0);
                default: begin
                    rdy = !(r == 9 && held < 5);
                    if (!rdy) held++;
                end
            endcase
            applyStimulus(1'b0, rand64(), 1'($urandom_range(0, 1)), rdy, 1'b0);
            if (rdy) j++;
            cycles++;
        end
        checkOutput({tag, "_accepted"}, 64'(j), 64'd16);
        checkOutput({tag, "_done"}, 64'(done), 64'h1);
        checkOutput({tag, "_end_valid"}, 64'(subkey_valid), 64'h0);
        checkOutput({tag, "_end_busy"}, 64'(busy), 64'h0);
    endtask

    initial begin
        tests        = 0;
        failures     = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        key_in       = 64'h0;
        decrypt      = 1'b0;
        abort        = 1'b0;
        subkey_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_subkey", 64'(subkey), 64'h0);
        checkOutput("reset_round", 64'(subkey_round), 64'h0);
        checkOutput("reset_valid", 64'(subkey_valid), 64'h0);
        checkOutput("reset_busy", 64'(busy), 64'h0);
        checkOutput("reset_done", 64'(done), 64'h0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("idle_valid", 64'(subkey_valid), 64'h0);

        // Encrypt known-answer vector.
        build_model(VEC_KEY);
        applyStimulus(1'b1, VEC_KEY, 1'b0, 1'b1, 1'b0);
        checkOutput("enc_k1", 64'(subkey), 64'h1B02EFFC7072);
        checkOutput("enc_r1", 64'(subkey_round), 64'd1);
        checkOutput("enc_busy", 64'(busy), 64'h1);
        applyStimulus(1'b0, rand64(), 1'b0, 1'b1, 1'b0);
        checkOutput("enc_k2", 64'(subkey), 64'h79AED9DBC9E5);
        checkOutput("enc_r2", 64'(subkey_round), 64'd2);
        for (int r = 3; r <= 16; r++) begin
            applyStimulus(1'b0, rand64(), 1'b0, 1'b1, 1'b0);
            checkOutput("enc_kn", 64'(subkey), 64'(ks[r]));
            checkOutput("enc_rn", 64'(subkey_round), 64'(r));
        end
        checkOutput("enc_k16", 64'(subkey), 64'hCB3D8B0E17F5);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("enc_done", 64'(done), 64'h1);
        checkOutput("enc_end_valid", 64'(subkey_valid), 64'h0);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("enc_done_pulse", 64'(done), 64'h0);

        run_schedule(VEC_KEY, 1'b0, 2, "bp");
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("bp_done_pulse", 64'(done), 64'h0);

        // Start during ROUND is ignored; abort beats start and handshake.
        key_a = rand64();
        build_model(key_a);
        applyStimulus(1'b1, key_a, 1'b0, 1'b1, 1'b0);
        for (int r = 1; r < 4; r++) applyStimulus(1'b0, rand64(), 1'b0, 1'b1, 1'b0);
        checkOutput("ab_r4", 64'(subkey_round), 64'd4);
        applyStimulus(1'b1, rand64(), 1'b0, 1'b1, 1'b0);
        checkOutput("ab_ign_r5", 64'(subkey_round), 64'd5);
        checkOutput("ab_ign_k5", 64'(subkey), 64'(ks[5]));
        applyStimulus(1'b0, rand64(), 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, rand64(), 1'b0, 1'b1, 1'b0);
        checkOutput("ab_k7", 64'(subkey), 64'(ks[7]));
        applyStimulus(1'b1, rand64(), 1'b0, 1'b1, 1'b1);
        checkOutput("ab_valid", 64'(subkey_valid), 64'h0);
        checkOutput("ab_busy", 64'(busy), 64'h0);
        checkOutput("ab_done", 64'(done), 64'h0);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("ab_idle_valid", 64'(subkey_valid), 64'h0);
        checkOutput("ab_idle_done", 64'(done), 64'h0);
        run_schedule(key_a, 1'b0, 0, "restart");

        // Decrypt order (encrypt order when the feature is not built in).
        applyStimulus(1'b1, VEC_KEY, 1'b1, 1'b1, 1'b0);
`ifdef DES_KEYSCHED_DECRYPT_EN
        checkOutput("dec_first", 64'(subkey), 64'hCB3D8B0E17F5);
        checkOutput("dec_first_r", 64'(subkey_round), 64'd16);
`else
        checkOutput("dec_first", 64'(subkey), 64'h1B02EFFC7072);
        checkOutput("dec_first_r", 64'(subkey_round), 64'd1);
`endif
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1'b1);
        checkOutput("dec_abort_valid", 64'(subkey_valid), 64'h0);
        run_schedule(VEC_KEY, 1'b1, 0, "dec");

        // Random keys back to back; each new start lands in the previous done cycle.
        for (int n = 0; n < 4; n++) run_schedule(rand64(), 1'($urandom_range(0, 1)), 1, "rnd");

        applyStimulus(1'b1, 64'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("b2b_subkey", 64'(subkey), 64'h0);
        checkOutput("b2b_round", 64'(subkey_round), 64'd1);
        checkOutput("b2b_busy", 64'(busy), 64'h1);

        // Asynchronous reset mid-schedule, between clock edges.
        applyStimulus(1'b0, rand64(), 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, rand64(), 1'b0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_subkey", 64'(subkey), 64'h0);
        checkOutput("arst_round", 64'(subkey_round), 64'h0);
        checkOutput("arst_valid", 64'(subkey_valid), 64'h0);
        checkOutput("arst_busy", 64'(busy), 64'h0);
        checkOutput("arst_done", 64'(done), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b0, rand64(), 1'b0, 1'b1, 1'b0);
            checkOutput("post_rst_valid", 64'(subkey_valid), 64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
